// File: rtl/display_scan_ctrl.sv
// Binary-to-BCD front end for a shared seven-segment decoder: converts a 14-bit
// value with a sequential double-dabble engine and time-multiplexes the digits.
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [13:0] value,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  dig_sel,
  output logic        dig_en,
  output logic [3:0]  an_n
);

  localparam int unsigned PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [13:0]  MAX_VALUE = 14'd9999;
  localparam logic [3:0]   LAST_STEP = 4'd13;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [13:0]   shift_q, shift_d;
  logic [15:0]   scratch_q, scratch_d;
  logic [3:0]    step_q, step_d;
  logic          pend_ovf_q, pend_ovf_d;
  logic [15:0]   disp_q, disp_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;

  logic [15:0]   scratch_adj;
  logic [15:0]   scratch_step;
  logic [13:0]   shift_step;
  logic          presc_wrap;
  logic          upper_zero;

  // One double-dabble step: correct every BCD nibble, then shift the pair left.
  // NOTE: every signal written in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    scratch_step = {scratch_adj[14:0], shift_q[13]};
    shift_step   = {shift_q[12:0], 1'b0};
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    step_d     = step_q;
    pend_ovf_d = pend_ovf_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          shift_d    = value;
          scratch_d  = '0;
          step_d     = '0;
          pend_ovf_d = (value > MAX_VALUE);
          state_d    = CONV;
        end
      end
      CONV: begin
        shift_d   = shift_step;
        scratch_d = scratch_step;
        step_d    = step_q + 4'd1;
        // The display only ever changes here, so the scan never sees partial digits.
        if (step_q == LAST_STEP) begin
          disp_d  = scratch_step;
          ovf_d   = pend_ovf_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples its pre-edge inputs regardless of block ordering.
  // NOTE: the display register and conversion scratch are small flop arrays,
  // not RAM, so they are reset: reset must abort a conversion and show "0".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      step_q     <= '0;
      pend_ovf_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      step_q     <= step_d;
      pend_ovf_q <= pend_ovf_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
    end
  end

  // Free-running scan timebase, deliberately independent of the converter.
  always_comb begin
    presc_wrap = (presc_q == PRESC_MAX);
    presc_d    = presc_wrap ? '0 : presc_q + PW'(1);
    idx_d      = presc_wrap ? idx_q + 2'd1 : idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Leading-zero test: the current digit and everything above it are zero.
  always_comb begin
    upper_zero = 1'b0;
    unique case (idx_q)
      2'd0: upper_zero = 1'b0;
      2'd1: upper_zero = (disp_q[15:4] == 12'd0);
      2'd2: upper_zero = (disp_q[15:8] == 8'd0);
      2'd3: upper_zero = (disp_q[15:12] == 4'd0);
      default: upper_zero = 1'b0;
    endcase
  end

  always_comb begin
    busy    = (state_q == CONV);
    ovf     = ovf_q;
    an_n    = ~(4'b0001 << idx_q);
    dig_sel = disp_q[{idx_q, 2'b00} +: 4];
    dig_en  = !ovf_q && !upper_zero;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Upstream driver for the BCD seven-segment decoder. It accepts a 14-bit binary value and converts it to four BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits onto one shared decoder, generating the decoder's `sel`/`enable` inputs and the active-low digit anode strobes. Leading zeros and out-of-range values are blanked through the decoder's `enable`.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays lit; legal range ≥ 2.
- `clk`  in  1  single system clock; all state on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `load`  in  1  one-cycle request to capture `value`; ignored while `busy`=1.
- `value`  in  14  unsigned binary to display; legal range 0..9999.
- `busy`  out  1  high while a conversion is in progress.
- `ovf`  out  1  last committed value was > 9999.
- `dig_sel`  out  4  BCD code of the currently scanned digit; feeds decoder `sel`.
- `dig_en`  out  1  decoder enable; 0 blanks the current digit.
- `an_n`  out  4  active-low digit strobes; bit 0 = units, bit 3 = thousands.

## Operation
- **FSM states:**
  - IDLE --load--> CONV.
  - CONV --14th step--> IDLE, committing the result.
- **Capture (IDLE, `load`=1):**
  - Latch `value` into the shift register.
  - Clear the BCD scratch to 0, clear the step counter, and set the pending-ovf flag = (`value` > 9999).
- **CONV step:** each cycle, add 3 to every scratch nibble ≥ 5, then shift {scratch, shift reg} left by 1. Fourteen steps total.
- **Commit:** after the 14th step, copy the scratch into the display register (4×4 bits) and copy pending-ovf into `ovf`. For overflow values the scratch content is don't-care, since the digits are blanked.
- **Hold:** the display register keeps the previous value for the whole conversion; the scan never shows partial results.
- **Scan:**
  - A prescaler counts 0..SCAN_DIV−1 continuously and is independent of the FSM.
  - On wrap, digit index idx advances 0→1→2→3→0.
- **Outputs:** combinational from registers.
  - `an_n` = ~(1 << idx).
  - `dig_sel` = display nibble idx.
- **Blanking (`dig_en`):**
  - `dig_en`=0 if `ovf`=1.
  - Else `dig_en`=0 if idx>0 and nibbles idx..3 are all zero.
  - Otherwise `dig_en`=1. The units digit is never blanked by zero suppression.
- **`load` during CONV:** ignored and not queued.

## Timing
- **Reset values (async assert, all registers):** FSM=IDLE, prescaler=0, idx=0, display=0, `busy`=0, `ovf`=0.
  - Resulting outputs: `an_n`=4'b1110, `dig_sel`=0, `dig_en`=1 (displays "0").
- **Conversion latency:**
  - `load` sampled at edge E0 → `busy`=1 after E0.
  - Steps occur on E1..E14; commit and `busy`=0 on E14.
  - `busy` is high for exactly 14 cycles. New digits are visible on `dig_sel` after E14.
- **Back-to-back loads:** a `load` in the cycle right after E14 (`busy`=0) is accepted, giving a 15-cycle minimum load-to-load period.
- **Scan timing:**
  - idx changes on the edge where the prescaler wraps SCAN_DIV−1→0, so each digit is lit for exactly SCAN_DIV cycles.
  - After reset, the first advance (idx 0→1) is at edge SCAN_DIV.
- **Simultaneous commit and prescaler wrap:** both take effect on the same edge; the new idx shows the new display data.
- **Reset mid-conversion:** aborts the conversion. The display returns to 0 and the pending value is lost.
- **`value` timing:** `value` is only sampled in the `load` cycle and may change freely afterwards.

## Test plan
- **Reset:** assert `rst_n`=0 mid-CONV → immediately `busy`=0, `an_n`=1110, `dig_sel`=0, `dig_en`=1, `ovf`=0.
- **Conversion (SCAN_DIV=4):** load 1234 → `busy` high 14 cycles; then over the following scans `an_n` 1110/1101/1011/0111 paired with `dig_sel` 4/3/2/1, all `dig_en`=1.
- **Zero suppression:**
  - Load 7 → units: `dig_sel`=7, `dig_en`=1; tens/hundreds/thousands: `dig_en`=0.
  - Load 1005 → all four enabled (1,0,0,5).
  - Load 0 → only units enabled.
- **Overflow:** load 10000 → after commit `ovf`=1 and `dig_en`=0 on all four digits; then load 9999 → `ovf`=0, digits 9,9,9,9.
- **Load while busy:** load 4321, then pulse `load` with 8888 at cycle 5 of CONV → 8888 ignored; display 4321; `busy` still falls after exactly 14 cycles.
- **Scan period:** with SCAN_DIV=4, count cycles between `an_n` changes → always 4, order 0→1→2→3→0, undisturbed by loads and commits.
